// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: reads the receiver FIFO, parses SYNC/ADDR/LEN/payload/CHK frames and releases checked payloads.
// Optional RX_TIMEOUT_EN adds an inter-byte timeout that aborts a stalled frame.
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_main,
    input  logic       rst_main_n,
    input  logic [7:0] rf_data,
    input  logic       rf_empty,
    output logic       rf_rd,
    output logic [7:0] pkt_addr,
    output logic [7:0] pkt_len,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD, CHK, DELIVER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_q, addr_d, len_q, len_d, chk_q, chk_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          rd_pend_q, err_pulse_q, err_pulse_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    mem_q [MAX_LEN];
    logic          byte_v, last, wr_en, tmo_hit;

    // A read issued last cycle means rf_data holds a fresh byte now.
    assign byte_v    = rd_pend_q;
    assign last      = (8'(idx_q) == len_q - 8'd1);
    assign rf_rd     = rst_main_n && (state_q != DELIVER) && !rf_empty && !rd_pend_q;
    assign pkt_valid = (state_q == DELIVER);
    assign pkt_data  = pkt_valid ? mem_q[idx_q] : 8'd0;
    assign pkt_last  = pkt_valid && last;
    assign pkt_addr  = addr_q;
    assign pkt_len   = len_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != HUNT);

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          counting;
    assign counting = (state_q == ADDR) || (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    assign tmo_hit  = counting && !byte_v && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign tmo_d    = (!counting || byte_v || tmo_hit) ? '0 : tmo_q + TW'(1);
    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) tmo_q <= '0;
        else             tmo_q <= tmo_d;
    end
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;
        case (state_q)
            HUNT: if (byte_v && rf_data == SYNC_BYTE) state_d = ADDR;
            ADDR: if (byte_v) begin
                addr_d  = rf_data;
                chk_d   = rf_data;
                state_d = LEN;
            end
            LEN: if (byte_v) begin
                if (rf_data == 8'd0 || rf_data > 8'(MAX_LEN)) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = 2'b01;
                    state_d     = HUNT;
                end else begin
                    len_d   = rf_data;
                    chk_d   = chk_q ^ rf_data;
                    idx_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (byte_v) begin
                wr_en   = 1'b1;
                chk_d   = chk_q ^ rf_data;
                idx_d   = idx_q + 1'b1;
                state_d = last ? CHK : PAYLOAD;
            end
            CHK: if (byte_v) begin
                if (rf_data == chk_q) begin
                    idx_d   = '0;
                    state_d = DELIVER;
                end else begin
                    err_pulse_d = 1'b1;
                    err_code_d  = 2'b10;
                    state_d     = HUNT;
                end
            end
            DELIVER: if (pkt_ready) begin
                idx_d   = idx_q + 1'b1;
                state_d = last ? HUNT : DELIVER;
            end
            default: state_d = HUNT;
        endcase
        if (tmo_hit) begin
            err_pulse_d = 1'b1;
            err_code_d  = 2'b11;
            state_d     = HUNT;
        end
    end

    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q     <= HUNT;
            addr_q      <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            idx_q       <= '0;
            rd_pend_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            rd_pend_q   <= rf_rd;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload store needs no reset; it is only read after a full frame is written.
    always_ff @(posedge clk_main) begin
        if (wr_en) mem_q[idx_q] <= rf_data;
    end
endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// tb_uart_rx_packet_ctrl: directed frames through a queue-modelled FIFO, checking delivery, errors and handshake.
module tb_uart_rx_packet_ctrl;
    logic       clk_main = 1'b0;
    logic       rst_main_n = 1'b0;
    logic [7:0] rf_data = 8'd0;
    logic       rf_empty = 1'b1;
    logic       rf_rd;
    logic [7:0] pkt_addr, pkt_len, pkt_data;
    logic       pkt_valid, pkt_last, err_pulse, busy;
    logic       pkt_ready = 1'b0;
    logic [1:0] err_code;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] fifo[$];
    logic [7:0] dq[$];
    logic       lq[$];
    logic [7:0] got_addr, got_len;
    int         n_err, n_wide;

    uart_rx_packet_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(40)) dut (
        .clk_main(clk_main), .rst_main_n(rst_main_n), .rf_data(rf_data), .rf_empty(rf_empty),
        .rf_rd(rf_rd), .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_data(pkt_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last),
        .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
    );

    always #5 clk_main = ~clk_main;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk_main) begin
        if (rf_rd) begin
            chk("rd_nonempty", 32'(fifo.size() != 0), 32'd1);
            if (fifo.size() != 0) rf_data <= fifo.pop_front();
        end
    end

    always @(negedge clk_main) rf_empty = (fifo.size() == 0);

    task automatic start();
        rst_main_n = 1'b0;
        pkt_ready  = 1'b1;
        fifo.delete();
        dq.delete();
        lq.delete();
        n_err  = 0;
        n_wide = 0;
        got_addr = 8'd0;
        got_len  = 8'd0;
        repeat (2) @(negedge clk_main);
    endtask

    task automatic release_rst();
        @(negedge clk_main);
        rst_main_n = 1'b1;
    endtask

    // hold>0: keep pkt_ready low for the first hold cycles of pkt_valid.
    task automatic run(input int ncyc, input int hold);
        int   held = 0;
        logic prev = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_main);
            if (pkt_valid && held < hold) begin
                pkt_ready = 1'b0;
                chk("hold_data", 32'(pkt_data), 32'h11);
                chk("hold_rd", 32'(rf_rd), 32'd0);
                chk("hold_fifo", 32'(fifo.size()), 32'd2);
                held++;
            end else begin
                pkt_ready = 1'b1;
            end
            if (pkt_valid && pkt_ready) begin
                dq.push_back(pkt_data);
                lq.push_back(pkt_last);
                got_addr = pkt_addr;
                got_len  = pkt_len;
            end
            if (err_pulse) n_err++;
            if (err_pulse && prev) n_wide++;
            prev = err_pulse;
        end
    endtask

    task automatic check_frame1(input string t);
        chk({t, "_n"}, 32'(dq.size()), 32'd3);
        if (dq.size() == 3) begin
            chk({t, "_d0"}, 32'(dq[0]), 32'h11);
            chk({t, "_d1"}, 32'(dq[1]), 32'h22);
            chk({t, "_d2"}, 32'(dq[2]), 32'h33);
            chk({t, "_last"}, 32'({lq[0], lq[1], lq[2]}), 32'b001);
        end
        chk({t, "_addr"}, 32'(got_addr), 32'h12);
        chk({t, "_len"}, 32'(got_len), 32'h03);
    endtask

    initial begin
        // 1: good frame, with reset-state checks while the FIFO is non-empty
        start();
        fifo = '{8'hA5, 8'h12, 8'h03, 8'h11, 8'h22, 8'h33, 8'h11};
        @(negedge clk_main);
        @(negedge clk_main);
        chk("rst_rd", 32'(rf_rd), 32'd0);
        chk("rst_out", 32'({pkt_valid, pkt_last, err_pulse, busy, err_code, pkt_data, pkt_addr, pkt_len}), 32'd0);
        release_rst();
        run(40, 0);
        check_frame1("t1");
        chk("t1_err", 32'(n_err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_code", 32'(err_code), 32'd0);

        // 2: bad checksum
        start();
        fifo = '{8'hA5, 8'h12, 8'h03, 8'h11, 8'h22, 8'h33, 8'h10};
        release_rst();
        run(40, 0);
        chk("t2_err", 32'(n_err), 32'd1);
        chk("t2_wide", 32'(n_wide), 32'd0);
        chk("t2_code", 32'(err_code), 32'b10);
        chk("t2_n", 32'(dq.size()), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);

        // 3: leading garbage discarded
        start();
        fifo = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h12, 8'h03, 8'h11, 8'h22, 8'h33, 8'h11};
        release_rst();
        run(50, 0);
        check_frame1("t3");
        chk("t3_err", 32'(n_err), 32'd0);

        // 4: LEN 0x11 exceeds MAX_LEN, then a good frame
        start();
        fifo = '{8'hA5, 8'h01, 8'h11, 8'hA5, 8'h12, 8'h03, 8'h11, 8'h22, 8'h33, 8'h11};
        release_rst();
        run(50, 0);
        chk("t4_err", 32'(n_err), 32'd1);
        chk("t4_code", 32'(err_code), 32'b01);
        check_frame1("t4");

        // 5: back-pressure for 10 cycles, two bytes queued behind the frame
        start();
        fifo = '{8'hA5, 8'h12, 8'h03, 8'h11, 8'h22, 8'h33, 8'h11, 8'hA5, 8'h99};
        release_rst();
        run(60, 10);
        check_frame1("t5");
        chk("t5_err", 32'(n_err), 32'd0);

        // 6: stall after SYNC/ADDR
        start();
        fifo = '{8'hA5, 8'h12};
        release_rst();
        run(55, 0);
`ifdef RX_TIMEOUT_EN
        chk("t6_err", 32'(n_err), 32'd1);
        chk("t6_code", 32'(err_code), 32'b11);
        chk("t6_busy", 32'(busy), 32'd0);
`else
        chk("t6_err", 32'(n_err), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
